// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the servo PWM generator.
//   state_e        : operating state of the output FSM (IDLE / RUN)
//   DEF_*          : default parameter values (50 MHz clk, 1 us tick, 20 ms period)
//   clamp_pw       : saturate a requested pulse width to [lo, hi]
//   pw_out_of_range: flag a request that clamp_pw would alter
package servo_pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH        = 16;
  localparam int unsigned DEF_PRESCALE     = 50;
  localparam int unsigned DEF_PERIOD_TICKS = 20000;
  localparam int unsigned DEF_MIN_PW       = 1000;
  localparam int unsigned DEF_MAX_PW       = 2000;

  // Saturate x to [lo, hi]; operands are zero-extended widths up to 32 bits.
  function automatic logic [31:0] clamp_pw(input logic [31:0] x,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    logic [31:0] r;
    r = x;
    if (x < lo) begin
      r = lo;
    end else if (x > hi) begin
      r = hi;
    end
    return r;
  endfunction

  // True when clamp_pw(x, lo, hi) != x.
  function automatic logic pw_out_of_range(input logic [31:0] x,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    return (x < lo) || (x > hi);
  endfunction

endpackage : servo_pwm_pkg

// File: rtl/servo_pwm_gen_prescaler.sv
// Clock prescaler: divides clk down to a one-clk tick every PRESCALE cycles.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous reset, active-low (tick_cnt -> 0)
//   tick  out high in the last clk of each PRESCALE-cycle window
//             (decoded from the counter register, so it is glitch-free and
//             aligned with the counter; no extra flop is added)
module pwm_prescaler #(
  parameter int unsigned PRESCALE = servo_pwm_pkg::DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] tick_cnt;

  // Free-running modulo-PRESCALE counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign tick = (tick_cnt == CNT_LAST);

endmodule : pwm_prescaler

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: turns pulse-width words (in ticks) into a servo PWM
// waveform. Words arrive through a valid/ready handshake into a one-entry
// shadow register, are clamped to [MIN_PW, MAX_PW] on acceptance, and are
// copied to the active width only at period boundaries so a pulse is never
// cut short or stretched.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous reset, active-low
//   en           in   run request, acted on at period boundaries only
//   pw_in        in   requested pulse width in ticks
//   pw_valid     in   pw_in valid this cycle
//   pw_ready     out  shadow register empty (transfer on pw_valid && pw_ready)
//   pwm_out      out  servo PWM output (registered)
//   period_start out  one-clk pulse in the cycle the period counter becomes 0
//   clamped      out  sticky: some accepted pw_in was out of range
module servo_pwm_gen
  import servo_pwm_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned PRESCALE     = DEF_PRESCALE,
  parameter int unsigned PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int unsigned MIN_PW       = DEF_MIN_PW,
  parameter int unsigned MAX_PW       = DEF_MAX_PW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] pw_in,
  input  logic             pw_valid,
  output logic             pw_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             clamped
);

  localparam logic [WIDTH-1:0] PERIOD_LAST = WIDTH'(PERIOD_TICKS - 1);
  localparam logic [WIDTH-1:0] MIN_W       = WIDTH'(MIN_PW);

  logic             tick;
  logic             boundary;
  logic             accept;
  logic [WIDTH-1:0] period_cnt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active_pw;
  logic [WIDTH-1:0] pw_sat;
  logic             pw_oor;
  state_e           state_q;
  state_e           state_d;
  logic             pwm_d;

  // Tick generator.
  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign boundary = tick && (period_cnt == PERIOD_LAST);
  assign accept   = pw_valid && pw_ready;

  // Saturated request and its out-of-range flag.
  assign pw_sat = WIDTH'(clamp_pw(32'(pw_in), 32'(MIN_PW), 32'(MAX_PW)));
  assign pw_oor = pw_out_of_range(32'(pw_in), 32'(MIN_PW), 32'(MAX_PW));

  // Period counter: advances per tick, wraps at PERIOD_TICKS-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (tick) begin
      if (period_cnt == PERIOD_LAST) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + WIDTH'(1);
      end
    end
  end

  // period_start marks the first clk of each period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
    end
  end

  // Shadow register. pw_ready doubles as the "shadow empty" flag. Accept and
  // consume are mutually exclusive: accept needs an empty shadow, the
  // boundary only consumes a full one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= MIN_W;
      pw_ready  <= 1'b1;
      active_pw <= MIN_W;
    end else if (accept) begin
      shadow   <= pw_sat;
      pw_ready <= 1'b0;
    end else if (boundary && !pw_ready) begin
      active_pw <= shadow;
      pw_ready  <= 1'b1;
    end
  end

  // Sticky clamp indicator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clamped <= 1'b0;
    end else if (accept && pw_oor) begin
      clamped <= 1'b1;
    end
  end

  // FSM state register and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pwm_out <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_out <= pwm_d;
    end
  end

  // Next state (boundary only, so a pulse in flight always completes) and
  // next PWM level.
  always_comb begin
    state_d = state_q;
    pwm_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (boundary && en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        pwm_d = (period_cnt < active_pw);
        if (boundary && !en) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : servo_pwm_gen
